// File: rtl/dcache.sv
// dcache: direct-mapped write-back, write-allocate data cache with zero-latency hits
module dcache #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic [31:0]  cache_addr,
  input  logic         cache_valid,
  input  logic         cache_write,
  input  logic [31:0]  cache_wr_data,
  input  logic [1:0]   cache_wr_size,
  output logic [31:0]  cache_rd_data,
  output logic         cache_ready,
  output logic         cache_miss,
  output logic [31:0]  mem_addr,
  output logic         mem_valid,
  output logic         mem_write,
  output logic [127:0] mem_wr_data,
  input  logic [127:0] mem_rd_data,
  input  logic         mem_ready
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 28 - IW;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state, state_nx;
  logic [127:0] data [NUM_LINES];
  logic [TW-1:0] tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  logic [31:4] miss_addr;
  logic [IW-1:0] idx, m_idx;
  logic [TW-1:0] tag;
  logic hit;
  logic [31:0] cur, byte_v, half_v, sd, new_word;
  logic [3:0] be;
  assign idx   = cache_addr[4 +: IW];
  assign tag   = cache_addr[31:4+IW];
  assign m_idx = miss_addr[4 +: IW];
  assign hit   = state == IDLE && valid[idx] && tags[idx] == tag;
  assign cur   = data[idx][{cache_addr[3:2], 5'b0} +: 32];
  assign cache_ready = cache_valid && hit;
  assign cache_miss  = (cache_valid && !hit) || state != IDLE;
  assign mem_valid   = state != IDLE;
  assign mem_write   = state == WRITEBACK;
  assign mem_addr    = state == WRITEBACK ? {tags[m_idx], m_idx, 4'b0} : {miss_addr, 4'b0};
  assign mem_wr_data = data[m_idx];
  // Load alignment and store byte-lane merge for the addressed word
  always_comb begin
    byte_v = cur >> {cache_addr[1:0], 3'b0};
    half_v = cur >> {cache_addr[1], 4'b0};
    cache_rd_data = cache_wr_size == SZ_BYTE ? {24'b0, byte_v[7:0]} :
                    cache_wr_size == SZ_HALF ? {16'b0, half_v[15:0]} : cur;
    be = cache_wr_size == SZ_BYTE ? 4'b0001 << cache_addr[1:0] :
         cache_wr_size == SZ_HALF ? (cache_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    sd = cache_wr_size == SZ_BYTE ? {4{cache_wr_data[7:0]}} :
         cache_wr_size == SZ_HALF ? {2{cache_wr_data[15:0]}} : cache_wr_data;
    new_word = cur;
    for (int b = 0; b < 4; b++) new_word[8*b +: 8] = be[b] ? sd[8*b +: 8] : cur[8*b +: 8];
  end
  // Miss handling: write back a dirty victim first, then fill
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE      ? (cache_valid && !hit ? (valid[idx] && dirty[idx] ? WRITEBACK : FILL) : IDLE) :
               state == WRITEBACK ? (mem_ready ? FILL : WRITEBACK) :
                                    (mem_ready ? IDLE : FILL);
  end
  // Control state: FSM, line valid/dirty bits and latched miss address
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cache_valid && !hit) miss_addr <= cache_addr[31:4];
      if (cache_ready && cache_write) dirty[idx] <= 1'b1;
      if (state == WRITEBACK && mem_ready) dirty[m_idx] <= 1'b0;
      if (state == FILL && mem_ready) begin
        valid[m_idx] <= 1'b1;
        dirty[m_idx] <= 1'b0;
      end
    end
  end
  // Data and tag arrays are not reset; writes are suppressed while reset is held
  always_ff @(posedge clk_i) begin
    if (reset_ni && state == FILL && mem_ready) begin
      data[m_idx] <= mem_rd_data;
      tags[m_idx] <= miss_addr[31:4+IW];
    end
    if (reset_ni && cache_ready && cache_write) data[idx][{cache_addr[3:2], 5'b0} +: 32] <= new_word;
  end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: randomized self-checking bench for dcache against a line-level reference model
module tb_dcache;
  localparam int NL = 16;
  localparam logic [1:0] WORD = 2'd0, HALF = 2'd1, BYTE = 2'd2;
  logic clk_i = 0, reset_ni = 0;
  logic [31:0] cache_addr = 0, cache_wr_data = 0, cache_rd_data, mem_addr;
  logic cache_valid = 0, cache_write = 0, cache_ready, cache_miss;
  logic [1:0] cache_wr_size = 0;
  logic mem_valid, mem_write, mem_ready = 0;
  logic [127:0] mem_wr_data, mem_rd_data = 0;
  int n_chk = 0, n_fail = 0;
  logic [127:0] mem [logic [27:0]];
  bit m_valid [NL];
  bit m_dirty [NL];
  logic [27:0] m_ln [NL];
  logic [127:0] m_data [NL];
  logic [127:0] wb_seen;
  logic [31:0] last_rd;

  always #5 clk_i = ~clk_i;

  dcache #(.NUM_LINES(NL)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .cache_addr(cache_addr), .cache_valid(cache_valid), .cache_write(cache_write),
    .cache_wr_data(cache_wr_data), .cache_wr_size(cache_wr_size),
    .cache_rd_data(cache_rd_data), .cache_ready(cache_ready), .cache_miss(cache_miss),
    .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] get_line(input logic [27:0] ln);
    if (!mem.exists(ln)) mem[ln] = {$urandom, $urandom, $urandom, $urandom};
    return mem[ln];
  endfunction

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  function automatic void span(input logic [31:0] a, input logic [1:0] sz, output int o, output int n);
    o = sz == BYTE ? int'(a[3:0]) : sz == HALF ? int'({a[3:1], 1'b0}) : int'({a[3:2], 2'b0});
    n = sz == BYTE ? 1 : sz == HALF ? 2 : 4;
  endfunction

  task automatic serve(input bit w, input logic [27:0] ln, input logic [127:0] exp, input int dly);
    int d;
    d = dly < 0 ? int'($urandom_range(0, 3)) : dly;
    for (int i = 0; i <= d; i++) begin
      #1;
      chk("mem_valid", 128'(mem_valid), 128'(1));
      chk("mem_write", 128'(mem_write), 128'(w));
      chk("mem_addr", 128'(mem_addr), 128'({ln, 4'b0}));
      chk("miss_pending", 128'(cache_miss), 128'(1));
      chk("ready_pending", 128'(cache_ready), 128'(0));
      if (w) begin
        chk("wb_data", mem_wr_data, exp);
        wb_seen = mem_wr_data;
      end else mem_rd_data = get_line(ln);
      mem_ready = (i == d);
      step;
    end
    mem_ready = 0;
    if (w) mem[ln] = exp;
  endtask

  task automatic access(input logic [31:0] a, input bit w, input logic [31:0] d, input logic [1:0] sz, input int dly);
    int i, o, n;
    logic [27:0] ln;
    logic [31:0] exp_rd;
    i = int'(a[7:4]);
    ln = a[31:4];
    cache_addr = a;
    cache_write = w;
    cache_wr_data = d;
    cache_wr_size = sz;
    cache_valid = 1;
    #1;
    if (!(m_valid[i] && m_ln[i] == ln)) begin
      chk("miss", 128'(cache_miss), 128'(1));
      chk("ready_on_miss", 128'(cache_ready), 128'(0));
      step;
      if (m_valid[i] && m_dirty[i]) begin
        serve(1, m_ln[i], m_data[i], -1);
        m_dirty[i] = 0;
      end
      serve(0, ln, get_line(ln), dly);
      m_valid[i] = 1;
      m_dirty[i] = 0;
      m_ln[i] = ln;
      m_data[i] = mem[ln];
      #1;
    end
    chk("ready", 128'(cache_ready), 128'(1));
    chk("miss_on_hit", 128'(cache_miss), 128'(0));
    span(a, sz, o, n);
    exp_rd = 0;
    for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = m_data[i][8*(o+k) +: 8];
    if (!w) begin
      chk("rd_data", 128'(cache_rd_data), 128'(exp_rd));
      last_rd = cache_rd_data;
    end
    step;
    if (w) begin
      for (int k = 0; k < n; k++) m_data[i][8*(o+k) +: 8] = d[8*k +: 8];
      m_dirty[i] = 1;
    end
    cache_valid = 0;
  endtask

  initial begin
    mem[28'h0000100] = {32'h0, 32'h0, 32'h44332211, 32'hDDCCBBAA};
    cache_valid = 1;
    cache_addr = 32'h1000;
    step;
    step;
    chk("rst_ready", 128'(cache_ready), 128'(0));
    chk("rst_miss", 128'(cache_miss), 128'(1));
    chk("rst_mem_valid", 128'(mem_valid), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    reset_ni = 1;
    cache_valid = 0;
    step;
    access(32'h1000, 0, 0, WORD, -1);
    chk("load_word", 128'(last_rd), 128'(32'hDDCCBBAA));
    access(32'h1003, 0, 0, BYTE, -1);
    chk("load_byte", 128'(last_rd), 128'(32'h000000DD));
    access(32'h1002, 0, 0, HALF, -1);
    chk("load_half", 128'(last_rd), 128'(32'h0000DDCC));
    access(32'h1001, 1, 32'h5A, BYTE, -1);
    access(32'h1000, 0, 0, WORD, -1);
    chk("store_then_load", 128'(last_rd), 128'(32'hDDCC5AAA));
    access(32'h1100, 0, 0, WORD, -1);
    chk("victim_word0", 128'(wb_seen[31:0]), 128'(32'hDDCC5AAA));
    access(32'h2000, 0, 0, WORD, 5);
    cache_addr = 32'h3040;
    cache_write = 0;
    cache_wr_size = WORD;
    cache_valid = 1;
    #1;
    chk("rf_miss", 128'(cache_miss), 128'(1));
    step;
    chk("rf_fill_active", 128'(mem_valid), 128'(1));
    reset_ni = 0;
    cache_valid = 0;
    step;
    reset_ni = 1;
    chk("rf_mem_valid", 128'(mem_valid), 128'(0));
    chk("rf_mem_write", 128'(mem_write), 128'(0));
    chk("rf_miss_idle", 128'(cache_miss), 128'(0));
    for (int k = 0; k < NL; k++) begin
      m_valid[k] = 0;
      m_dirty[k] = 0;
    end
    access(32'h3040, 0, 0, WORD, -1);
    access(32'h3047, 0, 0, WORD, -1);
    access(32'h3045, 0, 0, HALF, -1);
    for (int t = 0; t < 400; t++)
      access(32'h1000 + (($urandom % 4) << 8) + ($urandom % 256), 1'($urandom % 2), $urandom,
             2'($urandom_range(0, 2)), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines (power of 2, >=2).
REQ-002 SHALL use fixed 16-byte lines (4 words): offset addr[3:0], index addr[3+log2(NUM_LINES):4], tag = remaining upper bits.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 reset_ni  input  1  synchronous active-low reset.
REQ-006 cache_bus  slave  cache_interface  responder end of the CPU data-cache interface.
REQ-007 cache_bus.addr  in  32  byte address; cache_bus.valid  in  1  request present; cache_bus.write  in  1  store when 1.
REQ-008 cache_bus.wr_data  in  32  store data, low-aligned; cache_bus.wr_size  in  cache_access_size_t  WORD/HALF/BYTE.
REQ-009 cache_bus.rd_data  out  32  load data, low-aligned; cache_bus.ready  out  1  access done this cycle; cache_bus.miss  out  1  access pending.
REQ-010 mem_addr  out  32  line address, bits[3:0]=0; mem_valid  out  1  memory request; mem_write  out  1  1=line write-back, 0=line fill.
REQ-011 mem_wr_data  out  128  victim line; mem_rd_data  in  128  fill line; mem_ready  in  1  memory transfer completes this edge.

Function
REQ-012 Line state: valid bit, dirty bit and tag per line; data in registers; write-back, write-allocate.
REQ-013 FSM states: IDLE, WRITEBACK, FILL.
REQ-014 Hit = state IDLE and line[index].valid and tag match; evaluated combinationally from cache_bus.addr.
REQ-015 ready = valid & hit, same cycle as request (zero-latency hit); miss = valid & ~hit in IDLE, or state != IDLE.
REQ-016 ready and miss never both 1; both 0 when valid=0 in IDLE.
REQ-017 Load hit: rd_data = selected word shifted right by 8*addr[1:0] (BYTE) or 16*addr[1] (HALF), upper bits zero; CPU sign-extends.
REQ-018 Store hit: on the ready edge write only the byte lanes selected by wr_size/addr[1:0] from wr_data low bits; set dirty.
REQ-019 Misaligned access: HALF ignores addr[0], WORD ignores addr[1:0] (aligned down); no fault.
REQ-020 rd_data on store or miss cycles is don't-care.
REQ-021 IDLE and valid & ~hit: go to WRITEBACK if victim valid & dirty, else FILL; request address latched into a miss register.
REQ-022 WRITEBACK: mem_valid=1, mem_write=1, mem_addr={victim tag,index,4'b0}, mem_wr_data=victim line, all held stable; on edge with mem_ready=1 clear dirty, go FILL.
REQ-023 FILL: mem_valid=1, mem_write=0, mem_addr={latched tag,index,4'b0}; on edge with mem_ready=1 install mem_rd_data, set valid, clear dirty, write tag, go IDLE.
REQ-024 After FILL the still-held request hits in IDLE next cycle and completes per REQ-017/018 (miss penalty = write-back + fill + 1 cycle).
REQ-025 mem_ready may be 1 in the first cycle mem_valid rises; mem_ready ignored when mem_valid=0.
REQ-026 mem_valid=0 and mem_write=0 in IDLE; memory outputs combinational from state and miss register.
REQ-027 CPU SHALL hold addr/write/wr_data/wr_size stable while miss=1; cache uses latched address only for memory side.
REQ-028 Back-to-back hits: one access per cycle; store then load same word in next cycle returns the stored value.

Reset
REQ-029 reset_ni low at an edge: state IDLE, all valid and dirty bits 0, miss register 0; data/tag arrays not reset.
REQ-030 Reset outputs: ready=0, mem_valid=0, mem_write=0; miss=valid (every access misses).
REQ-031 Reset during WRITEBACK/FILL abandons the transfer; mem_valid low the cycle after; dirty data discarded.

Verification
REQ-032 After reset, load WORD 0x00001000 -> miss=1, FILL at mem_addr 0x00001000; mem returns 0x...44332211_DDCCBBAA (word0=0xDDCCBBAA); next cycle ready=1, rd_data=0xDDCCBBAA.
REQ-033 Load BYTE 0x00001003 and HALF 0x00001002 on hit line -> rd_data 0x000000DD and 0x0000DDCC, one cycle each.
REQ-034 Store BYTE 0x5A to 0x00001001 -> ready same cycle; following WORD load 0x00001000 returns 0xDDCC5AAA; line dirty.
REQ-035 Load 0x00001100 (same index, other tag, NUM_LINES=16) -> WRITEBACK mem_addr 0x00001000 with word0=0xDDCC5AAA, then FILL 0x00001100, then ready.
REQ-036 mem_ready delayed 5 cycles in FILL -> miss=1, mem_valid/mem_addr stable throughout; ready exactly one cycle after mem_ready edge.
REQ-037 reset_ni low during FILL -> mem_valid=0 next cycle; reload of the same address misses again.
